// File: rtl/operand_fetch_if.sv
// Operand fetch bus: decode request fields, execute-stage results and the
// single synchronous RAM/SFR read port.
interface operand_fetch_if #(
  parameter int MODE_W = 3
);
  // Request from decode
  logic              start;
  logic [MODE_W-1:0] a_mode;
  logic [MODE_W-1:0] b_mode;
  logic [7:0]        a_sel;
  logic [7:0]        b_sel;
  logic [7:0]        imm;
  logic [7:0]        acc_in;
  logic [7:0]        b_in;
  logic [7:0]        psw_in;
  logic [3:0]        alu_op_in;
  logic [7:0]        instr_in;
  // Memory read port
  logic              ram_rd_en;
  logic [7:0]        ram_addr;
  logic              ram_ind;
  logic [7:0]        ram_rd_data;
  // Results to execute
  logic              busy;
  logic              valid;
  logic [7:0]        a_data;
  logic [7:0]        b_data;
  logic [2:0]        a_bit_location;
  logic [2:0]        b_bit_location;
  logic              bit_en;
  logic [3:0]        alu_op;
  logic [7:0]        instruction;

  // Environment side: decode, memory and execute
  modport master (
    output start, a_mode, b_mode, a_sel, b_sel, imm, acc_in, b_in, psw_in,
           alu_op_in, instr_in, ram_rd_data,
    input  ram_rd_en, ram_addr, ram_ind, busy, valid, a_data, b_data,
           a_bit_location, b_bit_location, bit_en, alu_op, instruction
  );

  // Operand fetch stage side
  modport slave (
    input  start, a_mode, b_mode, a_sel, b_sel, imm, acc_in, b_in, psw_in,
           alu_op_in, instr_in, ram_rd_data,
    output ram_rd_en, ram_addr, ram_ind, busy, valid, a_data, b_data,
           a_bit_location, b_bit_location, bit_en, alu_op, instruction
  );
endinterface

// File: rtl/operand_fetch.sv
// Multi-cycle operand fetch: resolves operands A then B through one
// synchronous read port and hands them to execute with a one-cycle strobe.
module operand_fetch #(
  parameter logic [7:0] BIT_BASE = 8'h20,
  parameter int         MODE_W   = 3
) (
  input  logic          clk,
  input  logic          rst,
  operand_fetch_if.slave bus
);

  localparam logic [MODE_W-1:0] M_NONE = MODE_W'(0);
  localparam logic [MODE_W-1:0] M_ACC  = MODE_W'(1);
  localparam logic [MODE_W-1:0] M_IMM  = MODE_W'(2);
  localparam logic [MODE_W-1:0] M_REG  = MODE_W'(3);
  localparam logic [MODE_W-1:0] M_DIR  = MODE_W'(4);
  localparam logic [MODE_W-1:0] M_IND  = MODE_W'(5);
  localparam logic [MODE_W-1:0] M_BIT  = MODE_W'(6);
  localparam logic [MODE_W-1:0] M_BREG = MODE_W'(7);

  typedef enum logic [2:0] {
    S_IDLE, S_A_PTR, S_A_RD, S_A_CAP, S_B_PTR, S_B_RD, S_B_CAP, S_DONE
  } state_t;

  state_t            state_q;
  logic [MODE_W-1:0] b_mode_q;
  logic [7:0]        b_sel_q;
  logic [1:0]        rs_q;
  logic              rd_en_q, ind_q, busy_q, valid_q, bit_en_q;
  logic [7:0]        addr_q, a_data_q, b_data_q, instr_q;
  logic [2:0]        a_bit_q, b_bit_q;
  logic [3:0]        alu_op_q;

  // Only the register-bank bits of PSW steer addressing
  logic unused_psw_bits;
  assign unused_psw_bits = ^{bus.psw_in[7:5], bus.psw_in[2:0]};

  function automatic logic is_mem(input logic [MODE_W-1:0] m);
    return (m == M_REG) || (m == M_DIR) || (m == M_IND) || (m == M_BIT);
  endfunction

  // First address issued for a memory mode; for IND this is the pointer cell
  function automatic logic [7:0] first_addr(input logic [MODE_W-1:0] m,
                                            input logic [7:0] sel,
                                            input logic [1:0] rs);
    case (m)
      M_REG:   return {3'b000, rs, sel[2:0]};
      M_IND:   return {3'b000, rs, 2'b00, sel[0]};
      M_BIT:   return sel[7] ? {sel[7:3], 3'b000} : BIT_BASE + {4'h0, sel[6:3]};
      default: return sel;
    endcase
  endfunction

  function automatic logic [7:0] direct_val(input logic [MODE_W-1:0] m,
                                            input logic [7:0] acc,
                                            input logic [7:0] breg,
                                            input logic [7:0] im);
    case (m)
      M_ACC:   return acc;
      M_BREG:  return breg;
      M_IMM:   return im;
      default: return 8'h00;
    endcase
  endfunction

  // The second IND read targets the pointer byte arriving this very cycle
  assign bus.ram_addr       = ind_q ? bus.ram_rd_data : addr_q;
  assign bus.ram_rd_en      = rd_en_q;
  assign bus.ram_ind        = ind_q;
  assign bus.busy           = busy_q;
  assign bus.valid          = valid_q;
  assign bus.a_data         = a_data_q;
  assign bus.b_data         = b_data_q;
  assign bus.a_bit_location = a_bit_q;
  assign bus.b_bit_location = b_bit_q;
  assign bus.bit_en         = bit_en_q;
  assign bus.alu_op         = alu_op_q;
  assign bus.instruction    = instr_q;

  // Fetch sequencer with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      b_mode_q <= M_NONE;
      b_sel_q  <= 8'h00;
      rs_q     <= 2'b00;
      rd_en_q  <= 1'b0;
      ind_q    <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      bit_en_q <= 1'b0;
      addr_q   <= 8'h00;
      a_data_q <= 8'h00;
      b_data_q <= 8'h00;
      instr_q  <= 8'h00;
      a_bit_q  <= 3'd0;
      b_bit_q  <= 3'd0;
      alu_op_q <= 4'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            b_mode_q <= bus.b_mode;
            b_sel_q  <= bus.b_sel;
            rs_q     <= bus.psw_in[4:3];
            busy_q   <= 1'b1;
            alu_op_q <= bus.alu_op_in;
            instr_q  <= bus.instr_in;
            a_bit_q  <= (bus.a_mode == M_BIT) ? bus.a_sel[2:0] : 3'd0;
            b_bit_q  <= (bus.b_mode == M_BIT) ? bus.b_sel[2:0] : 3'd0;
            bit_en_q <= (bus.a_mode == M_BIT) || (bus.b_mode == M_BIT);
            if (!is_mem(bus.a_mode))
              a_data_q <= direct_val(bus.a_mode, bus.acc_in, bus.b_in, bus.imm);
            if (!is_mem(bus.b_mode))
              b_data_q <= direct_val(bus.b_mode, bus.acc_in, bus.b_in, bus.imm);
            if (is_mem(bus.a_mode)) begin
              rd_en_q <= 1'b1;
              addr_q  <= first_addr(bus.a_mode, bus.a_sel, bus.psw_in[4:3]);
              state_q <= (bus.a_mode == M_IND) ? S_A_PTR : S_A_RD;
            end else if (is_mem(bus.b_mode)) begin
              rd_en_q <= 1'b1;
              addr_q  <= first_addr(bus.b_mode, bus.b_sel, bus.psw_in[4:3]);
              state_q <= (bus.b_mode == M_IND) ? S_B_PTR : S_B_RD;
            end else begin
              valid_q <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_A_PTR: begin
          ind_q   <= 1'b1;
          state_q <= S_A_RD;
        end
        S_A_RD: begin
          rd_en_q <= 1'b0;
          ind_q   <= 1'b0;
          if (ind_q) addr_q <= bus.ram_rd_data;
          state_q <= S_A_CAP;
        end
        S_A_CAP: begin
          a_data_q <= bus.ram_rd_data;
          if (is_mem(b_mode_q)) begin
            rd_en_q <= 1'b1;
            addr_q  <= first_addr(b_mode_q, b_sel_q, rs_q);
            state_q <= (b_mode_q == M_IND) ? S_B_PTR : S_B_RD;
          end else begin
            valid_q <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_B_PTR: begin
          ind_q   <= 1'b1;
          state_q <= S_B_RD;
        end
        S_B_RD: begin
          rd_en_q <= 1'b0;
          ind_q   <= 1'b0;
          if (ind_q) addr_q <= bus.ram_rd_data;
          state_q <= S_B_CAP;
        end
        S_B_CAP: begin
          b_data_q <= bus.ram_rd_data;
          valid_q  <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: vector table plus hand sequences for
// double-indirect fetch, ignored starts and mid-fetch reset.
module tb_operand_fetch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  operand_fetch_if #(.MODE_W(3)) bus ();

  operand_fetch #(.BIT_BASE(8'h20), .MODE_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory model: registered read, separate direct/SFR and indirect spaces
  logic [7:0] mem_dir [256];
  logic [7:0] mem_ind [256];
  logic [7:0] rd_data_r = 8'h00;
  assign bus.ram_rd_data = rd_data_r;
  always @(posedge clk)
    if (bus.ram_rd_en)
      rd_data_r <= bus.ram_ind ? mem_ind[bus.ram_addr] : mem_dir[bus.ram_addr];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  localparam logic [2:0] NONE = 3'd0, ACC = 3'd1, IMM = 3'd2, REG = 3'd3,
                         DIR = 3'd4, IND = 3'd5, BIT = 3'd6, BREG = 3'd7;

  typedef struct {
    logic [2:0] am, bm;
    logic [7:0] as, bs, imm, acc, bv, psw;
    int         lat;
    logic [7:0] ea, eb;
    logic [2:0] eab, ebb;
    logic       ebe;
    int         rds;
    logic [7:0] addr0;
  } vec_t;

  vec_t vecs [7];

  task automatic drive_req(input logic [2:0] am, input logic [2:0] bm,
                           input logic [7:0] as, input logic [7:0] bs,
                           input logic [7:0] im, input logic [7:0] acc,
                           input logic [7:0] bv, input logic [7:0] psw,
                           input logic [3:0] op, input logic [7:0] ins);
    bus.a_mode = am; bus.b_mode = bm; bus.a_sel = as; bus.b_sel = bs;
    bus.imm = im; bus.acc_in = acc; bus.b_in = bv; bus.psw_in = psw;
    bus.alu_op_in = op; bus.instr_in = ins; bus.start = 1'b1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat = 0;
    int rds = 0;
    logic [7:0] addr0 = 8'h00;
    logic [3:0] op = 4'(idx + 1);
    logic [7:0] ins = 8'hA0 + 8'(idx);
    @(negedge clk);
    drive_req(v.am, v.bm, v.as, v.bs, v.imm, v.acc, v.bv, v.psw, op, ins);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk($sformatf("v%0d_busy_c1", idx), bus.busy, 1);
        // Scramble inputs: results must come from the latched request
        bus.start = 1'b0;
        bus.acc_in = ~v.acc; bus.imm = ~v.imm; bus.b_in = ~v.bv;
        bus.psw_in = ~v.psw; bus.a_sel = ~v.as; bus.b_sel = ~v.bs;
        bus.alu_op_in = ~op; bus.instr_in = ~ins;
      end
      if (bus.ram_rd_en) begin
        if (rds == 0) addr0 = bus.ram_addr;
        rds++;
      end
      if (bus.valid) begin
        lat = k;
        break;
      end
    end
    $display("vec %0d: lat=%0d a=%h b=%h abit=%0d bbit=%0d bit_en=%0b rds=%0d addr0=%h",
             idx, lat, bus.a_data, bus.b_data, bus.a_bit_location,
             bus.b_bit_location, bus.bit_en, rds, addr0);
    chk($sformatf("v%0d_latency", idx), lat, v.lat);
    chk($sformatf("v%0d_a_data", idx), bus.a_data, v.ea);
    chk($sformatf("v%0d_b_data", idx), bus.b_data, v.eb);
    chk($sformatf("v%0d_a_bit", idx), bus.a_bit_location, v.eab);
    chk($sformatf("v%0d_b_bit", idx), bus.b_bit_location, v.ebb);
    chk($sformatf("v%0d_bit_en", idx), bus.bit_en, v.ebe);
    chk($sformatf("v%0d_alu_op", idx), bus.alu_op, op);
    chk($sformatf("v%0d_instr", idx), bus.instruction, ins);
    chk($sformatf("v%0d_reads", idx), rds, v.rds);
    if (v.rds > 0) chk($sformatf("v%0d_addr0", idx), addr0, v.addr0);
    chk($sformatf("v%0d_busy_done", idx), bus.busy, 1);
    @(negedge clk);
    chk($sformatf("v%0d_valid_drop", idx), bus.valid, 0);
    chk($sformatf("v%0d_busy_drop", idx), bus.busy, 0);
    chk($sformatf("v%0d_a_hold", idx), bus.a_data, v.ea);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, bus.valid, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_rd_en"}, bus.ram_rd_en, 0);
    chk({tag, "_addr"}, bus.ram_addr, 0);
    chk({tag, "_ind"}, bus.ram_ind, 0);
    chk({tag, "_a_data"}, bus.a_data, 0);
    chk({tag, "_b_data"}, bus.b_data, 0);
    chk({tag, "_bits"}, {bus.a_bit_location, bus.b_bit_location, bus.bit_en}, 0);
    chk({tag, "_alu_op"}, bus.alu_op, 0);
    chk({tag, "_instr"}, bus.instruction, 0);
  endtask

  initial begin
    int lat;
    int nvalid;
    for (int i = 0; i < 256; i++) begin
      mem_dir[i] = 8'h00;
      mem_ind[i] = 8'h00;
    end
    mem_dir[8'h13] = 8'h77;
    mem_dir[8'h01] = 8'h90; mem_ind[8'h90] = 8'hAB;
    mem_dir[8'h25] = 8'hC5;
    mem_dir[8'hD0] = 8'h3E;
    mem_dir[8'h40] = 8'h12; mem_dir[8'h41] = 8'h34;
    mem_dir[8'h08] = 8'h85; mem_ind[8'h85] = 8'h5F;
    mem_dir[8'h18] = 8'hA1; mem_ind[8'hA1] = 8'h0F;
    mem_dir[8'h19] = 8'hB2; mem_ind[8'hB2] = 8'hF0;

    //          am    bm    as     bs     imm    acc    bv     psw    lat ea     eb     eab ebb ebe rds addr0
    vecs[0] = '{ACC,  IMM,  8'h00, 8'h00, 8'h3C, 8'h5A, 8'h00, 8'h00, 1, 8'h5A, 8'h3C, 0,  0,  0,  0,  8'h00};
    vecs[1] = '{REG,  NONE, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 3, 8'h77, 8'h00, 0,  0,  0,  1,  8'h13};
    vecs[2] = '{IND,  NONE, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4, 8'hAB, 8'h00, 0,  0,  0,  2,  8'h01};
    vecs[3] = '{BREG, BIT,  8'h00, 8'h2B, 8'h00, 8'h00, 8'h66, 8'h00, 3, 8'h66, 8'hC5, 0,  3,  1,  1,  8'h25};
    vecs[4] = '{BIT,  ACC,  8'hD7, 8'h00, 8'h00, 8'h11, 8'h00, 8'h00, 3, 8'h3E, 8'h11, 7,  0,  1,  1,  8'hD0};
    vecs[5] = '{DIR,  DIR,  8'h40, 8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 5, 8'h12, 8'h34, 0,  0,  0,  2,  8'h40};
    vecs[6] = '{NONE, IND,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08, 4, 8'h00, 8'h5F, 0,  0,  0,  2,  8'h08};

    drive_req(NONE, NONE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00);
    bus.start = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    $display("reset: outputs checked");
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Double indirect, PSW change at cycle 2, ignored start at cycle 3
    @(negedge clk);
    drive_req(IND, IND, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h18, 4'h9, 8'h55);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      case (k)
        1: begin
          chk("ii_c1_addr", {bus.ram_rd_en, bus.ram_ind, bus.ram_addr}, {2'b10, 8'h18});
          bus.start = 1'b0;
        end
        2: begin
          chk("ii_c2_addr", {bus.ram_rd_en, bus.ram_ind, bus.ram_addr}, {2'b11, 8'hA1});
          bus.psw_in = 8'h00;
        end
        3: begin
          bus.a_mode = ACC; bus.b_mode = IMM; bus.acc_in = 8'hEE; bus.start = 1'b1;
        end
        4: begin
          chk("ii_c4_addr", {bus.ram_rd_en, bus.ram_ind, bus.ram_addr}, {2'b10, 8'h19});
          bus.start = 1'b0;
        end
        5: chk("ii_c5_addr", {bus.ram_rd_en, bus.ram_ind, bus.ram_addr}, {2'b11, 8'hB2});
        default: ;
      endcase
      if (bus.valid) begin
        lat = k;
        break;
      end
    end
    $display("ind/ind: lat=%0d a=%h b=%h", lat, bus.a_data, bus.b_data);
    chk("ii_latency", lat, 7);
    chk("ii_a_data", bus.a_data, 8'h0F);
    chk("ii_b_data", bus.b_data, 8'hF0);
    nvalid = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.valid) nvalid++;
    end
    chk("ii_no_extra_valid", nvalid, 0);

    // Reset asserted while in A_RD aborts the fetch
    @(negedge clk);
    drive_req(DIR, BIT, 8'h40, 8'h2B, 8'h00, 8'h00, 8'h00, 8'h00, 4'h5, 8'h99);
    @(negedge clk);
    bus.start = 1'b0;
    chk("rst_in_ard", {bus.ram_rd_en, bus.ram_addr}, {1'b1, 8'h40});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("midrst");
    nvalid = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.valid) nvalid++;
    end
    $display("midrst: valid pulses after abort=%0d", nvalid);
    chk("midrst_no_valid", nvalid, 0);

    // Fresh start after reset, with a start in the DONE cycle
    drive_req(ACC, IMM, 8'h00, 8'h00, 8'h3C, 8'h5A, 8'h00, 8'h00, 4'h2, 8'h42);
    @(negedge clk);
    chk("fresh_valid_c1", bus.valid, 1);
    chk("fresh_data", {bus.a_data, bus.b_data}, 16'h5A3C);
    nvalid = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) bus.start = 1'b0;
      if (bus.valid) nvalid++;
    end
    $display("fresh: a=%h b=%h extra valid=%0d", bus.a_data, bus.b_data, nvalid);
    chk("done_start_ignored", nvalid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
Multi-cycle operand fetch stage directly upstream of the execute/process stage. On a start pulse from decode it resolves source operands A and B from their addressing modes. Sources are accumulator, B register, immediate, Rn, direct, @Ri indirect, or bit address. Memory operands are read through a single synchronous internal-RAM/SFR read port. The stage then presents a_data/b_data, bit locations, bit_en, alu_op and instruction to the execute stage with a one-cycle valid strobe.

Parameters:
BIT_BASE, 8'h20, byte address of the bit-addressable RAM region
MODE_W, 3, width of each addressing-mode field

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
start  input  1  one-cycle request from decode; ignored while busy=1
a_mode  input  3  source A mode: 0 NONE, 1 ACC, 2 IMM, 3 REG, 4 DIR, 5 IND, 6 BIT, 7 BREG
b_mode  input  3  source B mode, same encoding
a_sel  input  8  A selector: Rn index [2:0], Ri index [0], direct address, or bit address per mode
b_sel  input  8  B selector, same meaning
imm  input  8  immediate operand from instruction stream
acc_in  input  8  current ACC value
b_in  input  8  current B register value
psw_in  input  8  current PSW; RS1:RS0 = psw_in[4:3]
alu_op_in  input  4  ALU operation code from decode
instr_in  input  8  opcode byte from decode
ram_rd_en  output  1  read strobe
ram_addr  output  8  read address
ram_ind  output  1  1 = indirect-space access (upper RAM, not SFR) for addr >= 8'h80
ram_rd_data  input  8  read data, valid the cycle after ram_rd_en
busy  output  1  high from the cycle after accepted start until the DONE cycle inclusive
valid  output  1  one-cycle strobe; operand outputs valid
a_data  output  8  resolved operand A
b_data  output  8  resolved operand B
a_bit_location  output  3  bit index for A (BIT mode), else 0
b_bit_location  output  3  bit index for B (BIT mode), else 0
bit_en  output  1  1 if either mode is BIT
alu_op  output  4  latched alu_op_in
instruction  output  8  latched instr_in

Behaviour:
- Reset: state IDLE; every output 0, including ram_addr, ram_rd_en, ram_ind, busy, valid, operands and latched fields. Reset mid-operation aborts the fetch with no valid pulse.
- States: IDLE, A_PTR, A_RD, A_CAP, B_PTR, B_RD, B_CAP, DONE.
- IDLE with start=1: latch all mode, sel, imm, acc, b, psw, alu_op and instr inputs. Later input changes have no effect.
- Non-memory modes resolve in the cycle they are reached:
  - NONE -> 0
  - ACC -> acc_in
  - BREG -> b_in
  - IMM -> imm
- Memory mode addresses:
  - REG: {3'b000, RS1, RS0, sel[2:0]}
  - DIR: sel
  - BIT: sel<8'h80 -> BIT_BASE + sel[6:3]; else {sel[7:3], 3'b000}. bit_location = sel[2:0]. Operand is the full byte; execute extracts the bit.
  - IND: pointer at {3'b000, RS1, RS0, 2'b00, sel[0]}. Second read address = pointer value, with ram_ind=1.
- State sequence for A:
  - A_PTR (IND only): rd_en=1, addr = pointer address.
  - A_RD: rd_en=1, addr = ram_rd_data if IND, else the computed address.
  - A_CAP: a_data <= ram_rd_data.
  - B uses the same sequence, entered after A completes or straight from IDLE if A is non-memory.
- DONE is entered after B completes, or straight from IDLE/A_CAP when the remaining operand is non-memory. DONE: valid=1 for exactly one cycle, then IDLE.
- Latency (start cycle = 0): no memory operand -> valid at 1; one DIR/REG/BIT -> 3; one IND -> 4; two IND -> 7.
- ram_rd_en is 0 in all states other than *_PTR and *_RD. ram_addr holds its last value otherwise. ram_ind is 1 only in IND *_RD states.
- Operand and latched outputs hold after DONE until the next accepted start.
- start during busy: ignored, not queued. start in the DONE cycle: ignored.
- Bank bits come from the latched PSW, so a PSW change mid-fetch does not retarget the access.

Test Plan:
- Reset then start with a_mode=ACC, acc_in=8'h5A, b_mode=IMM, imm=8'h3C -> valid at cycle 1, a_data=5A, b_data=3C, no ram_rd_en.
- psw_in=8'h10 (bank 2), a_mode=REG, a_sel=3 -> ram_addr=8'h13 at cycle 1; RAM returns 8'h77 -> a_data=77, valid at cycle 3.
- a_mode=IND, a_sel=1, bank 0, RAM[01]=8'h90, RAM[90]=8'hAB -> addr 01 then 90 with ram_ind=1; a_data=AB, valid at cycle 4.
- b_mode=BIT, b_sel=8'h2B -> ram_addr=8'h25, b_bit_location=3, bit_en=1. b_sel=8'hD7 -> ram_addr=8'hD0, location 7.
- Both operands IND -> valid at cycle 7. A start pulse at cycle 3 is ignored. Changing psw_in at cycle 2 does not alter the B pointer address.
- Assert rst in A_RD -> next cycle IDLE, all outputs 0, no valid. A fresh start then completes normally.
